// File: rtl/spi_reg_bank_pkg.sv
// rtl/spi_reg_bank_pkg.sv - shared types, constants and sizing helpers for spi_reg_bank
package spi_reg_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Counter must hold FRAME_LEN itself, not just FRAME_LEN-1
    function automatic int cnt_width(input int addr_w, input int data_w);
        return clog2(frame_len(addr_w, data_w) + 1);
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// rtl/spi_reg_bank_if.sv - SPI pin bundle with controller (master) and peripheral (slave) views
interface spi_reg_bank_if;
    logic sclk;
    logic cs_n;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output cs_n, output copi, input cipo, input cipo_oe);
    modport slave  (input sclk, input cs_n, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank_sync_edge.sv
// rtl/spi_reg_bank_sync_edge.sv - multi-flop synchroniser with single-clk rise/fall pulses
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_dly;
    assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 register bank with readback; SPI_STATUS_REG_EN maps a status register at NUM_REGS
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FLEN    = frame_len(ADDR_W, DATA_W);
    localparam int CMD_LEN = 1 + ADDR_W;
    localparam int CNT_W   = cnt_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0]  CNT_CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_CMD_LEN   = CNT_W'(CMD_LEN);
    localparam logic [CNT_W-1:0]  CNT_DATA_LAST = CNT_W'(FLEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL      = CNT_W'(FLEN);
    localparam logic [ADDR_W:0]   NUM_REGS_W    = (ADDR_W+1)'(NUM_REGS);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic w_copi;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .i_async(spi.sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .i_async(spi.cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Same depth as the sclk chain so copi is sampled in the cycle sclk_rise is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_copi_sync <= '0;
        else        r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
    end
    assign w_copi = r_copi_sync[SYNC_STAGES-1];

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [FLEN-1:0]     r_shift;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_tx;
    logic                r_cipo, r_cipo_oe;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe;
    logic                r_frame_err;

    logic [FLEN-1:0]     w_shift_next;
    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr, w_cmd_addr;
    logic [DATA_W-1:0]   w_data, w_rd_data;
    logic                w_len_ok, w_addr_ok, w_commit, w_bad;
    logic [NUM_REGS-1:0] w_wr_onehot;

    assign w_shift_next = {r_shift[FLEN-2:0], w_copi};
    assign w_cmd_addr   = w_shift_next[ADDR_W-1:0];
    assign w_rw         = r_shift[FLEN-1];
    assign w_addr       = r_shift[DATA_W +: ADDR_W];
    assign w_data       = r_shift[DATA_W-1:0];
    assign w_len_ok     = (r_cnt == CNT_FULL) && !r_overrun;
    assign w_addr_ok    = ({1'b0, w_addr} < NUM_REGS_W);
    assign w_commit     = w_len_ok && (w_rw == RW_WRITE) && w_addr_ok;
    assign w_bad        = !w_len_ok || ((w_rw == RW_WRITE) && !w_addr_ok);

`ifdef SPI_STATUS_REG_EN
    localparam bit STATUS_MAPPED = (NUM_REGS < (1 << ADDR_W));
    logic [DATA_W-2:0] r_err_cnt;
    logic              r_last_ok;
    logic              w_is_status;
    assign w_is_status = STATUS_MAPPED && (w_cmd_addr == ADDR_W'(NUM_REGS));
`endif

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_cmd_addr == ADDR_W'(i)) w_rd_data = r_regs[i];
`ifdef SPI_STATUS_REG_EN
        if (w_is_status) w_rd_data = {r_err_cnt, r_last_ok};
`endif
    end

    always_comb begin
        w_wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_wr_onehot[i] = w_commit && (w_addr == ADDR_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            r_tx        <= '0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef SPI_STATUS_REG_EN
            r_err_cnt   <= '0;
            r_last_ok   <= 1'b0;
`endif
        end else begin
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            // cs_rise has priority so a coincident sclk_rise is never counted
            if (w_cs_rise) begin
                if (r_state != IDLE) begin
                    r_state     <= IDLE;
                    r_cipo      <= 1'b0;
                    r_cipo_oe   <= 1'b0;
                    r_wr_strobe <= w_wr_onehot;
                    r_frame_err <= w_bad;
                    for (int i = 0; i < NUM_REGS; i++)
                        if (w_wr_onehot[i]) r_regs[i] <= w_data;
`ifdef SPI_STATUS_REG_EN
                    r_last_ok <= !w_bad;
                    if (w_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
`endif
                end
            end else begin
                case (r_state)
                    IDLE: if (w_cs_fall) begin
                        r_state   <= CMD;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                        r_overrun <= 1'b0;
                    end
                    CMD: if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_CMD_LAST) begin
                            r_state <= DATA;
                            if (w_shift_next[ADDR_W] == RW_READ) begin
                                r_tx      <= w_rd_data;
                                r_cipo    <= w_rd_data[DATA_W-1];
                                r_cipo_oe <= 1'b1;
`ifdef SPI_STATUS_REG_EN
                                if (w_is_status) r_err_cnt <= '0;
`endif
                            end
                        end
                    end
                    DATA: if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_DATA_LAST) r_state <= OVER;
                    end else if (w_sclk_fall && r_cipo_oe && (r_cnt > CNT_CMD_LEN)) begin
                        // MSB must survive the fall before the first data rise
                        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                        r_cipo <= r_tx[DATA_W-2];
                    end
                    OVER: if (w_sclk_rise) r_overrun <= 1'b1;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign wr_strobe   = r_wr_strobe;
    assign frame_err   = r_frame_err;
    assign spi.cipo    = r_cipo;
    assign spi.cipo_oe = r_cipo_oe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank with a frame-level reference model
module tb_spi_reg_bank;

    localparam int NREG = 8;

    logic        clk;
    logic        rst_n;
    logic [63:0] regs_flat;
    logic [7:0]  wr_strobe;
    logic        frame_err;

    spi_reg_bank_if spi();

    spi_reg_bank #(.NUM_REGS(NREG), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  strobe;
        logic        err;
        logic [63:0] regs;
    } evt_t;

    evt_t q_evt[$];
    logic q_cipo[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_regs [NREG];
    logic [6:0] m_cnt;
    logic       m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_regs();
        logic [63:0] r;
        for (int i = 0; i < NREG; i++) r[i*8 +: 8] = m_regs[i];
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_cnt  = 7'd0;
        m_last = 1'b0;
    endfunction

    // Value a read of addr presents on cipo; reading status clears its error count
    function automatic logic [7:0] model_read(input logic [6:0] addr);
        logic [7:0] v;
        v = 8'h00;
        if (addr < 7'(NREG)) v = m_regs[addr[2:0]];
`ifdef SPI_STATUS_REG_EN
        else if (addr == 7'(NREG)) begin
            v = {m_cnt, m_last};
            m_cnt = 7'd0;
        end
`endif
        return v;
    endfunction

    // Monitor: every strobe/error pulse must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && (wr_strobe != 8'h00 || frame_err)) begin
            if (q_evt.size() == 0) begin
                chk("unexpected_pulse", {55'd0, frame_err, wr_strobe}, 64'd0);
            end else begin
                evt_t e;
                e = q_evt.pop_front();
                chk("wr_strobe", 64'(wr_strobe), 64'(e.strobe));
                chk("frame_err", 64'(frame_err), 64'(e.err));
                chk("regs_at_commit", regs_flat, e.regs);
            end
        end
    end

    // Monitor: controller samples cipo on sclk rise whenever the pad is driven
    always @(posedge spi.sclk) begin
        if (rst_n && !spi.cs_n && spi.cipo_oe) begin
            if (q_cipo.size() == 0) begin
                chk("unexpected_cipo", 64'(spi.cipo_oe), 64'd0);
            end else begin
                logic b;
                b = q_cipo.pop_front();
                chk("cipo_bit", 64'(spi.cipo), 64'(b));
            end
        end
    end

    task automatic run_frame(input int len, input logic rw, input logic [6:0] addr, input logic [7:0] data);
        logic [15:0] w;
        logic [7:0]  rd;
        logic        len_ok, bad;
        int          j;
        w = {rw, addr, data};
        if (len >= 8 && rw == 1'b0) begin
            rd = model_read(addr);
            for (int k = 8; k < len; k++) begin
                j = (k - 8 > 7) ? 7 : k - 8;
                q_cipo.push_back(rd[7 - j]);
            end
        end
        len_ok = (len == 16);
        bad    = !len_ok || (rw && addr >= 7'(NREG));
        if (len_ok && rw && addr < 7'(NREG)) begin
            m_regs[addr[2:0]] = data;
            q_evt.push_back('{strobe: 8'(1) << addr[2:0], err: 1'b0, regs: pack_regs()});
        end else if (bad) begin
            q_evt.push_back('{strobe: 8'h00, err: 1'b1, regs: pack_regs()});
        end
        m_last = !bad;
        if (bad && m_cnt != 7'h7F) m_cnt = m_cnt + 7'd1;

        @(posedge clk); #2;
        spi.cs_n = 1'b0;
        #30;
        for (int k = 0; k < len; k++) begin
            spi.copi = (k < 16) ? w[15-k] : 1'($urandom);
            #50 spi.sclk = 1'b1;
            #50 spi.sclk = 1'b0;
        end
        #30 spi.cs_n = 1'b1;
        spi.copi = 1'b0;
        #200;
        chk("cipo_oe_idle", 64'(spi.cipo_oe), 64'd0);
        chk("regs_flat", regs_flat, pack_regs());
        chk("cipo_drained", 64'(q_cipo.size()), 64'd0);
        chk("evt_drained", 64'(q_evt.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_regs", regs_flat, 64'd0);
        chk("rst_strobe", 64'(wr_strobe), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_cipo", 64'(spi.cipo), 64'd0);
        chk("rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
        spi.cs_n = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        model_reset();
        q_evt.delete();
        q_cipo.delete();
        #33 rst_n = 1'b1;
        #20;
    endtask

    initial begin
        spi.cs_n = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        rst_n    = 1'b1;
        #12;
        do_reset();

        run_frame(16, 1'b1, 7'd3, 8'hA5);
        run_frame(16, 1'b0, 7'd3, 8'h00);
        run_frame(12, 1'b1, 7'd1, 8'h77);
        run_frame(17, 1'b1, 7'd0, 8'hFF);
        run_frame(16, 1'b1, 7'd8, 8'h5A);
        run_frame(16, 1'b0, 7'd9, 8'h00);
        run_frame(18, 1'b0, 7'd3, 8'h00);

        // Reset after 9 bits of a write: outputs clear at once, then a clean frame commits
        @(posedge clk); #2;
        spi.cs_n = 1'b0;
        #30;
        for (int k = 0; k < 9; k++) begin
            spi.copi = (k == 0) ? 1'b1 : 1'($urandom);
            #50 spi.sclk = 1'b1;
            #50 spi.sclk = 1'b0;
        end
        #23;
        do_reset();
        run_frame(16, 1'b1, 7'd2, 8'h3C);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 3)      run_frame(16, 1'b1, 7'($urandom_range(0, 9)), 8'($urandom));
            else if (kind <= 6) run_frame(16, 1'b0, 7'($urandom_range(0, 9)), 8'($urandom));
            else if (kind <= 8) run_frame($urandom_range(0, 15), 1'($urandom), 7'($urandom_range(0, 9)), 8'($urandom));
            else                run_frame($urandom_range(17, 18), 1'($urandom), 7'($urandom_range(0, 9)), 8'($urandom));
        end

`ifdef SPI_STATUS_REG_EN
        do_reset();
        run_frame(5, 1'b1, 7'd1, 8'h11);
        run_frame(14, 1'b1, 7'd2, 8'h22);
        run_frame(16, 1'b1, 7'd4, 8'h44);
        run_frame(16, 1'b0, 7'd8, 8'h00);
        run_frame(16, 1'b0, 7'd8, 8'h00);
        run_frame(16, 1'b1, 7'd8, 8'h99);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
